axil_cmd_master: RTL and testbench
==================================

# axil_cmd_master

AXI-Lite initiator that turns a single-beat command stream (valid/ready) into one AXI-Lite read or write transaction and returns the result on a response stream. It sits upstream of the AXI-Lite demux and register slaves, driving their shared `axil_req_t` bus. It is the control-path master for firmware-less sequencers and test harnesses. Only one transaction is outstanding at a time.

## Interface

Parameters:
- `axil_req_t`, `logic`: AXI-Lite request struct. Fields:
  - AW: `aw_valid`, `aw.addr`
  - W: `w_valid`, `w.data`, `w.strb`
  - B: `b_ready`
  - AR: `ar_valid`, `ar.addr`
  - R: `r_ready`
- `axil_resp_t`, `logic`: AXI-Lite response struct. Fields:
  - AW/W: `aw_ready`, `w_ready`
  - B: `b_valid`, `b` (2-bit resp)
  - AR: `ar_ready`
  - R: `r_valid`, `r.data`, `r.resp`
- `AddrWidth`, 32: command address width.
- `DataWidth`, 32: data width. Must be a multiple of 8. Strobe width is `DataWidth/8`.

Ports:
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in AddrWidth: target address.
- `cmd_wdata` in DataWidth: write data (ignored for reads).
- `cmd_wstrb` in DataWidth/8: write strobes (ignored for reads).
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: result consumed.
- `rsp_write` out 1: echoes `cmd_write` of the completed transaction.
- `rsp_rdata` out DataWidth: read data; 0 for writes.
- `rsp_resp` out 2: AXI resp code taken from B or R.
- `m_axil_req` out axil_req_t: AXI-Lite request bus.
- `m_axil_resp` in axil_resp_t: AXI-Lite response bus.

## Operation

- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE: `cmd_ready`=1. On accept, latch addr/wdata/wstrb/write, then go to WR_REQ or RD_REQ.
- WR_REQ:
  - `aw_valid` and `w_valid` assert together.
  - Each drops independently in the cycle after its own ready is sampled high; address and data stay stable while valid.
  - The slave may complete AW before W, or W before AW.
  - Go to WR_RESP once both handshakes have completed; the two "done" flags clear on entry to IDLE.
- WR_RESP: `b_ready`=1. On `b_valid`, capture `b` into `rsp_resp`, clear `rsp_rdata`, go to DONE.
- RD_REQ: `ar_valid`=1 until `ar_ready`, then go to RD_RESP.
- RD_RESP: `r_ready`=1. On `r_valid`, capture `r.data` and `r.resp`, go to DONE.
- DONE: `rsp_valid`=1, outputs stable. On `rsp_ready`, go to IDLE.
- `cmd_ready` is 0 in every state except IDLE. Commands are never queued.
- All `m_axil_req` fields not listed above are driven 0. Read and write never overlap.
- Response codes pass through unmodified. An error code does not change FSM flow.

## Timing

- All outputs are registered except `cmd_ready`, which is decoded from state.
- Reset values:
  - state IDLE, `cmd_ready`=0 while `reset` is high.
  - All `m_axil_req` valid/ready bits 0.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_resp`=0, `rsp_write`=0.
- Accept at cycle T → AW/W/AR valid at T+1.
- With a zero-wait slave (ready at T+1, B/R at T+2): `rsp_valid` at T+3.
- Minimum command-to-command spacing is 4 cycles (includes the DONE handshake cycle).
- Simultaneous `aw_ready` and `w_ready`: both handshakes complete in the same cycle.
- `b_valid` or `r_valid` arriving in the same cycle as the last request handshake is not sampled. The ready for B/R rises only on the next state.
- `rsp_ready` held high: DONE lasts exactly 1 cycle.
- Reset mid-transaction: immediate return to IDLE with all valids low. The abandoned slave transaction is not tracked. The bench must also reset the slave.

## Structure

- Shared package `axil_pkg`:
  - `axil_resp_e` (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3).
  - Parameterized AXI-Lite req/resp struct typedefs used by all AXI-Lite blocks.
- State enum is local to the module.
- No sub-module. A single FSM plus capture registers.

## Test plan

- Write addr 0x10, data 0xDEADBEEF, strb 0xF, zero-wait slave → AW/W valid at T+1, `b_ready` at T+2, `rsp_valid` at T+3 with resp 0, `rsp_write`=1.
- Slave gives `aw_ready` 3 cycles before `w_ready` (registered, AW-then-W slave) → `aw_valid` drops after its handshake, `w_valid` held with data stable, single B accepted, resp 0.
- Read addr 0x4, slave returns 0x12345678 after 5-cycle `r_valid` delay → `r_ready` held 5 cycles, `rsp_rdata`=0x12345678, resp 0.
- Read returns SLVERR (2) → `rsp_resp`=2, FSM returns to IDLE, next command accepted normally.
- `rsp_ready` held low 10 cycles after completion → `rsp_valid` and data stable, `cmd_ready`=0 throughout; a new `cmd_valid` in that window is not accepted.
- Assert `reset` during WR_REQ (`aw_valid` high) → all valids low in the same cycle (async), `rsp_valid`=0; after release `cmd_ready`=1 and a read completes correctly.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions: response codes and the request/response bus structs
// used by every AXI-Lite block on this interconnect.
package axil_pkg;

   localparam int unsigned AXIL_ADDR_W = 32;
   localparam int unsigned AXIL_DATA_W = 32;
   localparam int unsigned AXIL_STRB_W = AXIL_DATA_W / 8;

   typedef enum logic [1:0] {
      OKAY   = 2'd0,
      EXOKAY = 2'd1,
      SLVERR = 2'd2,
      DECERR = 2'd3
   } axil_resp_e;

   typedef struct packed {
      logic [AXIL_ADDR_W-1:0] addr;
   } axil_ax_t;

   typedef struct packed {
      logic [AXIL_DATA_W-1:0] data;
      logic [AXIL_STRB_W-1:0] strb;
   } axil_w_t;

   typedef struct packed {
      logic [AXIL_DATA_W-1:0] data;
      logic [1:0]             resp;
   } axil_r_t;

   typedef struct packed {
      logic     aw_valid;
      axil_ax_t aw;
      logic     w_valid;
      axil_w_t  w;
      logic     b_ready;
      logic     ar_valid;
      axil_ax_t ar;
      logic     r_ready;
   } axil_req_t;

   typedef struct packed {
      logic       aw_ready;
      logic       w_ready;
      logic       b_valid;
      logic [1:0] b;
      logic       ar_ready;
      logic       r_valid;
      axil_r_t    r;
   } axil_resp_t;

endpackage

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI-Lite initiator: one command in, one AXI-Lite read or write
// transaction on the bus, one result out on the response stream.
module axil_cmd_master #(
   parameter int unsigned AddrWidth   = axil_pkg::AXIL_ADDR_W,
   parameter int unsigned DataWidth   = axil_pkg::AXIL_DATA_W,
   parameter type         axil_req_t  = axil_pkg::axil_req_t,
   parameter type         axil_resp_t = axil_pkg::axil_resp_t
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic                   cmd_write,
   input  logic [AddrWidth-1:0]   cmd_addr,
   input  logic [DataWidth-1:0]   cmd_wdata,
   input  logic [DataWidth/8-1:0] cmd_wstrb,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic                   rsp_write,
   output logic [DataWidth-1:0]   rsp_rdata,
   output logic [1:0]             rsp_resp,
   output axil_req_t              m_axil_req,
   input  axil_resp_t             m_axil_resp
);

   localparam int unsigned StrbWidth = DataWidth / 8;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RESP,
      RD_REQ,
      RD_RESP,
      DONE
   } state_e;

   state_e                 state_q;
   logic                   write_q;
   logic [AddrWidth-1:0]   addr_q;
   logic [DataWidth-1:0]   wdata_q;
   logic [StrbWidth-1:0]   wstrb_q;
   logic                   aw_valid_q, w_valid_q, aw_done_q, w_done_q;
   logic                   b_ready_q, ar_valid_q, r_ready_q;
   logic                   rsp_valid_q, rsp_write_q;
   logic [DataWidth-1:0]   rsp_rdata_q;
   logic [1:0]             rsp_resp_q;

   logic aw_hs, w_hs, wr_req_done;

   // AW and W complete independently; the write phase ends once both have been seen.
   assign aw_hs       = aw_valid_q & m_axil_resp.aw_ready;
   assign w_hs        = w_valid_q & m_axil_resp.w_ready;
   assign wr_req_done = (aw_done_q | aw_hs) & (w_done_q | w_hs);

   assign cmd_ready = (state_q == IDLE) && !reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         aw_valid_q  <= 1'b0;
         w_valid_q   <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         b_ready_q   <= 1'b0;
         ar_valid_q  <= 1'b0;
         r_ready_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= 2'd0;
      end else begin
         // NOTE: every register here uses <= so all of them see the pre-edge state.
         unique case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  write_q <= cmd_write;
                  addr_q  <= cmd_addr;
                  wdata_q <= cmd_wdata;
                  wstrb_q <= cmd_wstrb;
                  if (cmd_write) begin
                     aw_valid_q <= 1'b1;
                     w_valid_q  <= 1'b1;
                     state_q    <= WR_REQ;
                  end else begin
                     ar_valid_q <= 1'b1;
                     state_q    <= RD_REQ;
                  end
               end
            end
            WR_REQ: begin
               if (aw_hs) begin
                  aw_valid_q <= 1'b0;
                  aw_done_q  <= 1'b1;
               end
               if (w_hs) begin
                  w_valid_q <= 1'b0;
                  w_done_q  <= 1'b1;
               end
               if (wr_req_done) begin
                  b_ready_q <= 1'b1;
                  state_q   <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (m_axil_resp.b_valid) begin
                  b_ready_q   <= 1'b0;
                  rsp_resp_q  <= m_axil_resp.b;
                  rsp_rdata_q <= '0;
                  rsp_write_q <= write_q;
                  rsp_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            RD_REQ: begin
               if (m_axil_resp.ar_ready) begin
                  ar_valid_q <= 1'b0;
                  r_ready_q  <= 1'b1;
                  state_q    <= RD_RESP;
               end
            end
            RD_RESP: begin
               if (m_axil_resp.r_valid) begin
                  r_ready_q   <= 1'b0;
                  rsp_rdata_q <= m_axil_resp.r.data;
                  rsp_resp_q  <= m_axil_resp.r.resp;
                  rsp_write_q <= write_q;
                  rsp_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  aw_done_q   <= 1'b0;
                  w_done_q    <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_write = rsp_write_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_resp  = rsp_resp_q;

   // Bus fields are pure wiring of registers; anything not driven below stays 0.
   always_comb begin
      m_axil_req          = '0;
      m_axil_req.aw_valid = aw_valid_q;
      m_axil_req.aw.addr  = addr_q;
      m_axil_req.w_valid  = w_valid_q;
      m_axil_req.w.data   = wdata_q;
      m_axil_req.w.strb   = wstrb_q;
      m_axil_req.b_ready  = b_ready_q;
      m_axil_req.ar_valid = ar_valid_q;
      m_axil_req.ar.addr  = addr_q;
      m_axil_req.r_ready  = r_ready_q;
   end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: the bench plays the AXI-Lite slave cycle by cycle
// and checks responses against a scoreboard of expected results.
module tb_axil_cmd_master;
   import axil_pkg::*;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = DW / 8;

   logic            clk = 1'b0;
   logic            reset;
   logic            cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0]   cmd_addr;
   logic [DW-1:0]   cmd_wdata;
   logic [SW-1:0]   cmd_wstrb;
   logic            rsp_valid, rsp_ready, rsp_write;
   logic [DW-1:0]   rsp_rdata;
   logic [1:0]      rsp_resp;
   axil_req_t       m_axil_req;
   axil_resp_t      m_axil_resp;

   typedef struct {
      logic          write;
      logic [DW-1:0] rdata;
      logic [1:0]    resp;
   } exp_t;

   exp_t sb[$];
   int   checks_total  = 0;
   int   checks_passed = 0;

   always #5 clk = ~clk;

   axil_cmd_master dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .cmd_wstrb   (cmd_wstrb),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_write   (rsp_write),
      .rsp_rdata   (rsp_rdata),
      .rsp_resp    (rsp_resp),
      .m_axil_req  (m_axil_req),
      .m_axil_resp (m_axil_resp)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks_total++;
      assert (obs === exp) checks_passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one command for one cycle and record what the response must be.
   task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [SW-1:0] wstrb, input logic [DW-1:0] exp_rdata,
                           input logic [1:0] exp_resp);
      exp_t e;
      check("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      cmd_wstrb = wstrb;
      e.write = wr;
      e.rdata = wr ? '0 : exp_rdata;
      e.resp  = exp_resp;
      sb.push_back(e);
      tick();
      cmd_valid = 1'b0;
      check("cmd_ready_busy", cmd_ready, 0);
      check("aw_valid_t1", m_axil_req.aw_valid, wr);
      check("w_valid_t1", m_axil_req.w_valid, wr);
      check("ar_valid_t1", m_axil_req.ar_valid, !wr);
      if (wr) begin
         check("aw_addr", m_axil_req.aw.addr, addr);
         check("w_data", m_axil_req.w.data, wdata);
         check("w_strb", m_axil_req.w.strb, wstrb);
      end else begin
         check("ar_addr", m_axil_req.ar.addr, addr);
      end
   endtask

   // Wait (bounded) for a response with rsp_ready high and compare it with the scoreboard.
   task automatic wait_rsp(input int budget);
      exp_t e;
      int   n = 0;
      while (!rsp_valid && n < budget) begin
         tick();
         n++;
      end
      check("rsp_valid_seen", rsp_valid, 1);
      if (rsp_valid) begin
         check("sb_depth", sb.size(), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rsp_write", rsp_write, e.write);
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_resp", rsp_resp, e.resp);
         end
         tick();
         check("done_one_cycle", rsp_valid, 0);
         check("cmd_ready_after", cmd_ready, 1);
      end
   endtask

   task automatic do_write_zero(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                input logic [SW-1:0] strb, input logic [1:0] resp);
      send_cmd(1'b1, addr, data, strb, '0, resp);
      m_axil_resp.aw_ready = 1'b1;
      m_axil_resp.w_ready  = 1'b1;
      tick();
      check("b_ready_t2", m_axil_req.b_ready, 1);
      check("aw_valid_drop", m_axil_req.aw_valid, 0);
      check("w_valid_drop", m_axil_req.w_valid, 0);
      m_axil_resp.aw_ready = 1'b0;
      m_axil_resp.w_ready  = 1'b0;
      m_axil_resp.b_valid  = 1'b1;
      m_axil_resp.b        = resp;
      tick();
      m_axil_resp.b_valid = 1'b0;
      check("b_ready_drop", m_axil_req.b_ready, 0);
      check("rsp_valid_t3", rsp_valid, 1);
      wait_rsp(0);
   endtask

   // Runs a read up to the DONE state; the caller consumes the response.
   task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [1:0] resp, input int delay);
      send_cmd(1'b0, addr, '0, '0, data, resp);
      m_axil_resp.ar_ready = 1'b1;
      tick();
      m_axil_resp.ar_ready = 1'b0;
      check("ar_valid_drop", m_axil_req.ar_valid, 0);
      check("r_ready_t2", m_axil_req.r_ready, 1);
      for (int i = 0; i < delay; i++) begin
         tick();
         check("r_ready_hold", m_axil_req.r_ready, 1);
      end
      m_axil_resp.r_valid  = 1'b1;
      m_axil_resp.r.data   = data;
      m_axil_resp.r.resp   = resp;
      tick();
      m_axil_resp.r_valid = 1'b0;
      check("r_ready_drop", m_axil_req.r_ready, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset       = 1'b1;
      m_axil_resp = '0;
      cmd_valid   = 1'b0;
      cmd_write   = 1'b0;
      cmd_addr    = '0;
      cmd_wdata   = '0;
      cmd_wstrb   = '0;
      rsp_ready   = 1'b1;
      #2;
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_req_bits", {m_axil_req.aw_valid, m_axil_req.w_valid, m_axil_req.b_ready,
                             m_axil_req.ar_valid, m_axil_req.r_ready}, 5'b0);
      check("rst_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, '0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("cmd_ready_post_rst", cmd_ready, 1);

      // Zero-wait write.
      do_write_zero(32'h10, 32'hDEAD_BEEF, 4'hF, OKAY);

      // Slave takes AW three cycles before W.
      send_cmd(1'b1, 32'h20, 32'hA5A5_0F0F, 4'h3, '0, OKAY);
      m_axil_resp.aw_ready = 1'b1;
      tick();
      m_axil_resp.aw_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("aw_valid_low", m_axil_req.aw_valid, 0);
         check("w_valid_held", m_axil_req.w_valid, 1);
         check("w_data_stable", m_axil_req.w.data, 32'hA5A5_0F0F);
         check("b_ready_wait", m_axil_req.b_ready, 0);
         if (i < 2) tick();
      end
      m_axil_resp.w_ready = 1'b1;
      tick();
      m_axil_resp.w_ready = 1'b0;
      check("w_valid_drop_late", m_axil_req.w_valid, 0);
      check("b_ready_late", m_axil_req.b_ready, 1);
      m_axil_resp.b_valid = 1'b1;
      m_axil_resp.b       = OKAY;
      tick();
      m_axil_resp.b_valid = 1'b0;
      check("single_b", m_axil_req.b_ready, 0);
      wait_rsp(2);

      // Read with a 5-cycle R delay.
      do_read(32'h4, 32'h1234_5678, OKAY, 5);
      wait_rsp(0);

      // Error responses pass through; following commands behave normally.
      do_read(32'hC, 32'h0BAD_0BAD, SLVERR, 1);
      wait_rsp(0);
      do_write_zero(32'h14, 32'h0000_0001, 4'h1, DECERR);
      do_write_zero(32'h18, 32'h5555_AAAA, 4'hC, OKAY);

      // Consumer stalls for 10 cycles while a new command is offered.
      rsp_ready = 1'b0;
      do_read(32'h8, 32'hCAFE_F00D, EXOKAY, 0);
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'h40;
      cmd_wdata = 32'h7777_7777;
      cmd_wstrb = 4'hF;
      for (int i = 0; i < 10; i++) begin
         check("stall_rsp_valid", rsp_valid, 1);
         check("stall_rdata", rsp_rdata, 32'hCAFE_F00D);
         check("stall_cmd_ready", cmd_ready, 0);
         check("stall_no_req", m_axil_req.aw_valid | m_axil_req.ar_valid, 0);
         tick();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      wait_rsp(0);

      // Reset in the middle of a write request.
      send_cmd(1'b1, 32'h30, 32'h1111_2222, 4'hF, '0, OKAY);
      reset       = 1'b1;
      m_axil_resp = '0;
      #1;
      check("arst_req_bits", {m_axil_req.aw_valid, m_axil_req.w_valid, m_axil_req.b_ready,
                              m_axil_req.ar_valid, m_axil_req.r_ready}, 5'b0);
      check("arst_rsp_valid", rsp_valid, 0);
      check("arst_cmd_ready", cmd_ready, 0);
      void'(sb.pop_back());
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("cmd_ready_rerst", cmd_ready, 1);
      do_read(32'h4, 32'h1357_9BDF, OKAY, 2);
      wait_rsp(0);

      check("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
